systolic_seq_ctrl: RTL and testbench

//  Sequencer for the SIZE x SIZE systolic MAC array.
//  On START it clears the PE accumulators, then drives the diagonally skewed row/column feed enables for an NxN product.
//  It waits for the array to drain, then streams C out row-major over an AXI-stream master.

---
 rtl/systolic_seq_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: sequencer for a SIZE x SIZE systolic MAC array.
// It clears the PE accumulators, drives the skewed row/column feed enables,
// waits for the array to drain, then streams C row-major on an AXI-stream master.
// Optional build macro SEQ_PERF_CNT_EN adds the perf_cycles/perf_stall counters.
module systolic_seq_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE       = 6,
  parameter int PE_LAT     = 1,
  localparam int CNT_W     = $clog2(2*SIZE) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   N,
  input  logic                         START,
  output logic                         busy,
  output logic                         err_bad_n,
  output logic                         pe_clr,
  output logic                         pe_en,
  output logic [CNT_W-1:0]             feed_cnt,
  output logic [SIZE-1:0]              row_en,
  output logic [SIZE-1:0]              col_en,
  input  logic [SIZE*SIZE*DATA_WIDTH-1:0] c_matrix,
  output logic [DATA_WIDTH-1:0]        m_axis_data,
  output logic                         m_axis_valid,
  input  logic                         m_axis_ready,
  output logic                         m_axis_last,
`ifdef SEQ_PERF_CNT_EN
  output logic [31:0]                  perf_cycles,
  output logic [31:0]                  perf_stall,
`endif
  output logic                         GLOBAL_DONE
);

  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int EL_W  = (SIZE > 1) ? $clog2(SIZE*SIZE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_STREAM, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       row_q, row_d, col_q, col_d;
  logic [3:0]             nq_q, nq_d;

  logic                   busy_q, busy_d, err_q, err_d, clr_q, clr_d, en_q, en_d;
  logic                   valid_q, valid_d, last_q, last_d, done_q, done_d;
  logic [CNT_W-1:0]       fcnt_q, fcnt_d;
  logic [SIZE-1:0]        rowen_q, rowen_d, colen_q, colen_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;

  logic [DATA_WIDTH-1:0]  c_elem [SIZE*SIZE];
  logic [CNT_W-1:0]       nq_ext, feed_last, drain_len;
  logic [IDX_W-1:0]       last_idx;
  logic [EL_W-1:0]        elem_idx;
  logic                   n_ok;

  // Physical-stride view of the array results, one element per PE.
  for (genvar k = 0; k < SIZE*SIZE; k++) begin : g_elem
    assign c_elem[k] = c_matrix[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign n_ok      = (N != 4'd0) && (int'(N) <= SIZE);
  assign nq_ext    = CNT_W'(nq_q);
  assign feed_last = (nq_ext << 1) - CNT_W'(2);
  assign drain_len = nq_ext + CNT_W'(PE_LAT) - CNT_W'(1);
  assign last_idx  = IDX_W'(nq_q - 4'd1);

  // Next-state and counter logic: phase sequencing and the row-major C walk.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    nq_d    = nq_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        row_d = '0;
        col_d = '0;
        if (START) begin
          if (n_ok) begin
            nq_d    = N;
            state_d = S_CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_FEED;
      end
      S_FEED: begin
        if (cnt_q == feed_last) begin
          cnt_d   = '0;
          // A zero-length drain (only possible with PE_LAT=0, N=1) skips DRAIN.
          state_d = (drain_len == '0) ? S_STREAM : S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == drain_len - 1'b1) begin
          cnt_d   = '0;
          state_d = S_STREAM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STREAM: begin
        if (m_axis_ready) begin
          if (col_q == last_idx) begin
            col_d = '0;
            if (row_q == last_idx) state_d = S_DONE;
            else                   row_d   = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output leaves a flop (Moore, registered).
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    clr_d    = (state_d == S_CLEAR);
    en_d     = (state_d == S_FEED) || (state_d == S_DRAIN);
    fcnt_d   = (state_d == S_FEED) ? cnt_d : '0;
    rowen_d  = '0;
    if (state_d == S_FEED) begin
      for (int r = 0; r < SIZE; r++) begin
        rowen_d[r] = (r < int'(nq_d)) && (r <= int'(cnt_d)) && (int'(cnt_d) < r + int'(nq_d));
      end
    end
    colen_d  = rowen_d;
    valid_d  = (state_d == S_STREAM);
    last_d   = valid_d && (row_d == last_idx) && (col_d == last_idx);
    done_d   = (state_d == S_DONE);
    elem_idx = EL_W'(row_d) * EL_W'(SIZE) + EL_W'(col_d);
    data_d   = '0;
    if (valid_d) begin
      // Hold the offered beat explicitly while the sink back-pressures.
      data_d = (state_q == S_STREAM && !m_axis_ready) ? data_q : c_elem[elem_idx];
    end
  end

  // FSM state, counters and registered outputs; async reset returns everything to IDLE/0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      nq_q    <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      fcnt_q  <= '0;
      rowen_q <= '0;
      colen_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      nq_q    <= nq_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      clr_q   <= clr_d;
      en_q    <= en_d;
      fcnt_q  <= fcnt_d;
      rowen_q <= rowen_d;
      colen_q <= colen_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      data_q  <= data_d;
    end
  end

  assign busy         = busy_q;
  assign err_bad_n    = err_q;
  assign pe_clr       = clr_q;
  assign pe_en        = en_q;
  assign feed_cnt     = fcnt_q;
  assign row_en       = rowen_q;
  assign col_en       = colen_q;
  assign m_axis_data  = data_q;
  assign m_axis_valid = valid_q;
  assign m_axis_last  = last_q;
  assign GLOBAL_DONE  = done_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] pcyc_q, pcyc_d, pstall_q, pstall_d;
  logic        accept;

  assign accept = (state_q == S_IDLE) && START && n_ok;

  // Saturating busy-cycle and stall counters, restarted when a START is accepted.
  always_comb begin
    pcyc_d   = pcyc_q;
    pstall_d = pstall_q;
    if (accept) begin
      pcyc_d   = '0;
      pstall_d = '0;
    end else begin
      if (busy_q && (pcyc_q != '1))                         pcyc_d   = pcyc_q + 1'b1;
      if (valid_q && !m_axis_ready && (pstall_q != '1))     pstall_d = pstall_q + 1'b1;
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcyc_q   <= '0;
      pstall_q <= '0;
    end else begin
      pcyc_q   <= pcyc_d;
      pstall_q <= pstall_d;
    end
  end

  assign perf_cycles = pcyc_q;
  assign perf_stall  = pstall_q;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl: randomized runs checked cycle by
// cycle against a phase-timeline model and a row-major beat queue.
module tb_systolic_seq_ctrl;
  localparam int DW = 32;
  localparam int SZ = 6;
  localparam int PL = 1;
  localparam int CW = $clog2(2*SZ) + 1;
  localparam int VW = 3 + 2*SZ + CW + 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [3:0]             N;
  logic                   START;
  logic                   busy, err_bad_n, pe_clr, pe_en;
  logic [CW-1:0]          feed_cnt;
  logic [SZ-1:0]          row_en, col_en;
  logic [SZ*SZ*DW-1:0]    c_matrix;
  logic [DW-1:0]          m_axis_data;
  logic                   m_axis_valid, m_axis_ready, m_axis_last, GLOBAL_DONE;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]            perf_cycles, perf_stall;
`endif

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] cm [SZ][SZ];
  logic [VW-1:0] obs;

  systolic_seq_ctrl #(.DATA_WIDTH(DW), .SIZE(SZ), .PE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .N(N), .START(START),
    .busy(busy), .err_bad_n(err_bad_n), .pe_clr(pe_clr), .pe_en(pe_en),
    .feed_cnt(feed_cnt), .row_en(row_en), .col_en(col_en), .c_matrix(c_matrix),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid),
    .m_axis_ready(m_axis_ready), .m_axis_last(m_axis_last),
`ifdef SEQ_PERF_CNT_EN
    .perf_cycles(perf_cycles), .perf_stall(perf_stall),
`endif
    .GLOBAL_DONE(GLOBAL_DONE)
  );

  always #5 clk = ~clk;

  assign obs = {busy, pe_clr, pe_en, row_en, col_en, feed_cnt,
                m_axis_valid, m_axis_last, GLOBAL_DONE, err_bad_n};

  // Expected control vector for cycle k after acceptance (k=1 is the clear cycle), before STREAM.
  function automatic logic [VW-1:0] exp_ctl(input int k, input int n);
    logic [SZ-1:0] re;
    logic [CW-1:0] fc;
    bit feed, drain;
    int t;
    feed  = (k >= 2) && (k <= 2*n);
    drain = (k > 2*n) && (k < 3*n + PL);
    t  = k - 2;
    re = '0;
    fc = '0;
    if (feed) begin
      fc = CW'(t);
      // Row r receives its N operands during wavefronts r .. r+N-1.
      for (int r = 0; r < n; r++) if (t >= r && t < r + n) re[r] = 1'b1;
    end
    return {1'b1, (k == 1), (feed || drain), re, re, fc, 4'b0000};
  endfunction

  task automatic fill_matrix();
    for (int r = 0; r < SZ; r++) begin
      for (int c = 0; c < SZ; c++) begin
        cm[r][c] = $urandom();
        c_matrix[(r*SZ + c)*DW +: DW] = cm[r][c];
      end
    end
  endtask

  // One full product; entered and left at a negedge with the DUT in IDLE.
  task automatic run_product(input int n, input int rmode, input bit keep,
                             output int done_k, output int stalls);
    logic [DW-1:0] q[$];
    logic [VW-1:0] ev;
    int k, ks, guard, p;
    bit rdy;
    fill_matrix();
    for (int r = 0; r < n; r++) for (int c = 0; c < n; c++) q.push_back(cm[r][c]);
    N = 4'(n); START = 1'b1; m_axis_ready = 1'b1;
    @(negedge clk); k = 1;
    N = 4'($urandom_range(0, 15));
    if (!keep) START = 1'b0;
    ks = 3*n + PL;
    while (k < ks) begin
      ev = exp_ctl(k, n);
      checks++;
      if (obs !== ev) begin
        errors++;
        $display("FAIL ctl n=%0d cycle=%0d got=%h exp=%h", n, k, obs, ev);
      end
      @(negedge clk); k++;
    end
    stalls = 0; guard = 0; p = 0;
    while (q.size() > 0 && guard < 1000) begin
      ev = {3'b100, {(2*SZ+CW){1'b0}}, 1'b1, (q.size() == 1), 2'b00};
      checks++;
      if (obs !== ev) begin
        errors++;
        $display("FAIL stream_ctl n=%0d cycle=%0d got=%h exp=%h", n, k, obs, ev);
      end
      checks++;
      if (m_axis_data !== q[0]) begin
        errors++;
        $display("FAIL data n=%0d beat=%0d got=%h exp=%h", n, p, m_axis_data, q[0]);
      end
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (guard % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      m_axis_ready = rdy;
      if (!rdy) stalls++;
      @(negedge clk); k++; guard++;
      if (rdy) begin void'(q.pop_front()); p++; end
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL stream_timeout n=%0d left=%0d exp=0", n, q.size());
    end
    done_k = k;
    ev = {3'b100, {(2*SZ+CW){1'b0}}, 4'b0010};
    checks++;
    if (obs !== ev) begin
      errors++;
      $display("FAIL done n=%0d cycle=%0d got=%h exp=%h", n, k, obs, ev);
    end
    checks++;
    if (k != ks + n*n + stalls) begin
      errors++;
      $display("FAIL latency n=%0d got=%0d exp=%0d", n, k, ks + n*n + stalls);
    end
    m_axis_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL idle n=%0d got=%h exp=0", n, obs);
    end
`ifdef SEQ_PERF_CNT_EN
    checks++;
    if (perf_cycles !== 32'(done_k)) begin
      errors++;
      $display("FAIL perf_cycles n=%0d got=%0d exp=%0d", n, perf_cycles, done_k);
    end
    checks++;
    if (perf_stall !== 32'(stalls)) begin
      errors++;
      $display("FAIL perf_stall n=%0d got=%0d exp=%0d", n, perf_stall, stalls);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; START = 1'b0; N = 4'd0; m_axis_ready = 1'b0; c_matrix = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== '0 || m_axis_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h data=%h exp=0", obs, m_axis_data);
    end
`ifdef SEQ_PERF_CNT_EN
    checks++;
    if (perf_cycles !== 32'd0 || perf_stall !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_cycles, perf_stall);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL post_reset_idle got=%h exp=0", obs);
    end
  endtask

  task automatic test_n2();
    int dk, st;
    run_product(2, 0, 1'b0, dk, st);
    checks++;
    if (dk != 11) begin
      errors++;
      $display("FAIL n2_done_cycle got=%0d exp=11", dk);
    end
  endtask

  task automatic test_n6();
    int dk, st;
    run_product(6, 0, 1'b0, dk, st);
    checks++;
    if (dk != 55 || st != 0) begin
      errors++;
      $display("FAIL n6_done_cycle got=%0d stalls=%0d exp=55/0", dk, st);
    end
  endtask

  task automatic test_stall();
    int dk, st;
    run_product(3, 1, 1'b0, dk, st);
    checks++;
    if (dk != 35 || st != 16) begin
      errors++;
      $display("FAIL stall_pattern done=%0d stalls=%0d exp=35/16", dk, st);
    end
  endtask

  task automatic test_bad_n();
    int dk, st;
    logic [3:0] bad [3] = '{4'd0, 4'd7, 4'd15};
    for (int i = 0; i < 3; i++) begin
      N = bad[i]; START = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== VW'(1)) begin
        errors++;
        $display("FAIL bad_n_pulse n=%0d got=%h exp=%h", bad[i], obs, VW'(1));
      end
      START = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL bad_n_clear n=%0d got=%h exp=0", bad[i], obs);
      end
    end
    run_product(1, 0, 1'b0, dk, st);
    checks++;
    if (dk != 5) begin
      errors++;
      $display("FAIL n1_done_cycle got=%0d exp=5", dk);
    end
  endtask

  task automatic test_reset_midrun();
    int dk, st, g;
    fill_matrix();
    N = 4'd4; START = 1'b1;
    @(negedge clk);
    START = 1'b0; g = 0;
    while (feed_cnt !== CW'(2) && g < 20) begin @(negedge clk); g++; end
    checks++;
    if (feed_cnt !== CW'(2)) begin
      errors++;
      $display("FAIL reach_feed2 got=%0d exp=2", feed_cnt);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== '0 || m_axis_data !== '0) begin
      errors++;
      $display("FAIL midrun_reset got=%h data=%h exp=0", obs, m_axis_data);
    end
    @(negedge clk);
    rst = 1'b0;
    run_product(2, 0, 1'b0, dk, st);
    checks++;
    if (dk != 11) begin
      errors++;
      $display("FAIL after_reset_done got=%0d exp=11", dk);
    end
  endtask

  task automatic test_back_to_back();
    int dk, st;
    run_product(2, 0, 1'b1, dk, st);
    run_product(2, 0, 1'b1, dk, st);
    run_product(2, 0, 1'b0, dk, st);
    checks++;
    if (dk != 11) begin
      errors++;
      $display("FAIL b2b_done got=%0d exp=11", dk);
    end
  endtask

  task automatic test_random();
    int dk, st;
    for (int i = 0; i < 6; i++) run_product($urandom_range(1, SZ), 2, 1'b0, dk, st);
  endtask

  initial begin
    test_reset();
    test_n2();
    test_n6();
    test_stall();
    test_bad_n();
    test_reset_midrun();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
